// File: rtl/axi4_outstanding_limiter_if.sv
// AXI4 bundle shared by the limiter's bridge-facing and DDR-facing ports.
// Widths come from the AXI4_*_WIDTH macros, defaulted here when not supplied.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 64
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif

interface axi4_if;
    logic [`AXI4_ID_WIDTH-1:0]     awid;
    logic [`AXI4_ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]                    awlen;
    logic [2:0]                    awsize;
    logic [1:0]                    awburst;
    logic                          awlock;
    logic [3:0]                    awcache;
    logic [2:0]                    awprot;
    logic [3:0]                    awqos;
    logic                          awvalid;
    logic                          awready;
    logic [`AXI4_DATA_WIDTH-1:0]   wdata;
    logic [`AXI4_DATA_WIDTH/8-1:0] wstrb;
    logic                          wlast;
    logic                          wvalid;
    logic                          wready;
    logic [`AXI4_ID_WIDTH-1:0]     bid;
    logic [1:0]                    bresp;
    logic                          bvalid;
    logic                          bready;
    logic [`AXI4_ID_WIDTH-1:0]     arid;
    logic [`AXI4_ADDR_WIDTH-1:0]   araddr;
    logic [7:0]                    arlen;
    logic [2:0]                    arsize;
    logic [1:0]                    arburst;
    logic                          arlock;
    logic [3:0]                    arcache;
    logic [2:0]                    arprot;
    logic [3:0]                    arqos;
    logic                          arvalid;
    logic                          arready;
    logic [`AXI4_ID_WIDTH-1:0]     rid;
    logic [`AXI4_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                    rresp;
    logic                          rlast;
    logic                          rvalid;
    logic                          rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_outstanding_limiter.sv
// Caps in-flight AXI4 reads/writes, gates traffic until PHY calibration, drain handshake; watchdog via AXI4_LIMITER_TIMEOUT_EN.
// Latency: 0 cycles on every channel; AR/AW enables are registered from state and next counter values.
// Backpressure: only AR/AW valid/ready are gated; W, B and R always pass straight through.
module axi4_outstanding_limiter #(
    parameter int MAX_RD         = 16,
    parameter int MAX_WR         = 16,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             phy_init_done,
    axi4_if.slave            s_axi,
    axi4_if.master           m_axi,
    input  logic             drain_req,
    output logic             drain_ack,
    output logic [CNT_W-1:0] rd_outstanding,
    output logic [CNT_W-1:0] wr_outstanding,
    output logic             timeout_err
);
    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_DRAINED = 2'd3;

    localparam logic [CNT_W-1:0] RD_LIM = CNT_W'(MAX_RD);
    localparam logic [CNT_W-1:0] WR_LIM = CNT_W'(MAX_WR);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic             ar_en_q, ar_en_d, aw_en_q, aw_en_d;
    logic             rd_inc, rd_dec, wr_inc, wr_dec;

    assign m_axi.awid    = s_axi.awid;
    assign m_axi.awaddr  = s_axi.awaddr;
    assign m_axi.awlen   = s_axi.awlen;
    assign m_axi.awsize  = s_axi.awsize;
    assign m_axi.awburst = s_axi.awburst;
    assign m_axi.awlock  = s_axi.awlock;
    assign m_axi.awcache = s_axi.awcache;
    assign m_axi.awprot  = s_axi.awprot;
    assign m_axi.awqos   = s_axi.awqos;
    assign m_axi.awvalid = s_axi.awvalid & aw_en_q;
    assign s_axi.awready = m_axi.awready & aw_en_q;

    assign m_axi.wdata   = s_axi.wdata;
    assign m_axi.wstrb   = s_axi.wstrb;
    assign m_axi.wlast   = s_axi.wlast;
    assign m_axi.wvalid  = s_axi.wvalid;
    assign s_axi.wready  = m_axi.wready;

    assign s_axi.bid     = m_axi.bid;
    assign s_axi.bresp   = m_axi.bresp;
    assign s_axi.bvalid  = m_axi.bvalid;
    assign m_axi.bready  = s_axi.bready;

    assign m_axi.arid    = s_axi.arid;
    assign m_axi.araddr  = s_axi.araddr;
    assign m_axi.arlen   = s_axi.arlen;
    assign m_axi.arsize  = s_axi.arsize;
    assign m_axi.arburst = s_axi.arburst;
    assign m_axi.arlock  = s_axi.arlock;
    assign m_axi.arcache = s_axi.arcache;
    assign m_axi.arprot  = s_axi.arprot;
    assign m_axi.arqos   = s_axi.arqos;
    assign m_axi.arvalid = s_axi.arvalid & ar_en_q;
    assign s_axi.arready = m_axi.arready & ar_en_q;

    assign s_axi.rid     = m_axi.rid;
    assign s_axi.rdata   = m_axi.rdata;
    assign s_axi.rresp   = m_axi.rresp;
    assign s_axi.rlast   = m_axi.rlast;
    assign s_axi.rvalid  = m_axi.rvalid;
    assign m_axi.rready  = s_axi.rready;

    assign rd_inc = m_axi.arvalid & m_axi.arready;
    assign rd_dec = m_axi.rvalid & m_axi.rready & m_axi.rlast;
    assign wr_inc = m_axi.awvalid & m_axi.awready;
    assign wr_dec = m_axi.bvalid & m_axi.bready;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (rd_inc && !rd_dec && rd_cnt_q != RD_LIM)
            rd_cnt_d = rd_cnt_q + 1'b1;
        else if (!rd_inc && rd_dec && rd_cnt_q != '0)
            rd_cnt_d = rd_cnt_q - 1'b1;

        wr_cnt_d = wr_cnt_q;
        if (wr_inc && !wr_dec && wr_cnt_q != WR_LIM)
            wr_cnt_d = wr_cnt_q + 1'b1;
        else if (!wr_inc && wr_dec && wr_cnt_q != '0)
            wr_cnt_d = wr_cnt_q - 1'b1;
    end

    // DRAIN exits on the next counter values so a late handshake cannot slip past the ack.
    always_comb begin
        state_d = state_q;
        if (!phy_init_done) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT:    state_d = ST_RUN;
                ST_RUN:     if (drain_req) state_d = ST_DRAIN;
                ST_DRAIN:   if (rd_cnt_d == '0 && wr_cnt_d == '0) state_d = ST_DRAINED;
                ST_DRAINED: if (!drain_req) state_d = ST_RUN;
                default:    state_d = ST_INIT;
            endcase
        end
    end

    // State gates one cycle late (in-flight handshakes finish); the limit uses the next count.
    assign ar_en_d = (state_q == ST_RUN) && (rd_cnt_d < RD_LIM);
    assign aw_en_d = (state_q == ST_RUN) && (wr_cnt_d < WR_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            ar_en_q  <= 1'b0;
            aw_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            ar_en_q  <= ar_en_d;
            aw_en_q  <= aw_en_d;
        end
    end

    assign drain_ack      = (state_q == ST_DRAINED);
    assign rd_outstanding = rd_cnt_q;
    assign wr_outstanding = wr_cnt_q;

`ifdef AXI4_LIMITER_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
    logic        to_q, to_d;

    always_comb begin
        wd_d = wd_q;
        to_d = to_q;
        if ((rd_cnt_q == '0 && wr_cnt_q == '0) || rd_dec || wr_dec)
            wd_d = '0;
        else if (wd_q != '1)
            wd_d = wd_q + 32'd1;
        if (wd_d >= 32'(TIMEOUT_CYCLES))
            to_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign timeout_err = to_q;
`else
    assign timeout_err = 1'b0;
`endif

    a_params:     assert property (@(posedge clk) (2**CNT_W > MAX_RD) && (2**CNT_W > MAX_WR) && (TIMEOUT_CYCLES > 0));
    a_rd_ovf:     assert property (@(posedge clk) disable iff (!rst_n) !(rd_inc && !rd_dec && rd_cnt_q == RD_LIM));
    a_rd_undf:    assert property (@(posedge clk) disable iff (!rst_n) !(rd_dec && !rd_inc && rd_cnt_q == '0));
    a_wr_ovf:     assert property (@(posedge clk) disable iff (!rst_n) !(wr_inc && !wr_dec && wr_cnt_q == WR_LIM));
    a_wr_undf:    assert property (@(posedge clk) disable iff (!rst_n) !(wr_dec && !wr_inc && wr_cnt_q == '0));
endmodule

// File: tb/tb_axi4_outstanding_limiter.sv
// Directed bench for axi4_outstanding_limiter: AR scoreboard plus immediate-assertion checks.
module tb_axi4_outstanding_limiter;
    localparam int MAX_RD = 4;
    localparam int MAX_WR = 4;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             phy_init_done = 1'b0;
    logic             drain_req = 1'b0;
    logic             drain_ack, timeout_err;
    logic [CNT_W-1:0] rd_out, wr_out;

    int tests = 0;
    int fails = 0;
    logic [`AXI4_ADDR_WIDTH-1:0] exp_ar[$];
    logic [`AXI4_ADDR_WIDTH-1:0] exp_addr;
    bit ok;
    logic exp_to;

    axi4_if s_if();
    axi4_if m_if();

    always #5 clk = ~clk;

    axi4_outstanding_limiter #(
        .MAX_RD(MAX_RD), .MAX_WR(MAX_WR), .CNT_W(CNT_W), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .phy_init_done(phy_init_done),
        .s_axi(s_if), .m_axi(m_if),
        .drain_req(drain_req), .drain_ack(drain_ack),
        .rd_outstanding(rd_out), .wr_outstanding(wr_out),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an AR and holds it; returns with it still held if not accepted within budget.
    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input int budget, output bit acc);
        s_if.arvalid = 1'b1;
        s_if.araddr  = addr;
        s_if.arlen   = len;
        exp_ar.push_back(addr);
        acc = 1'b0;
        for (int c = 0; c < budget && !acc; c++) begin
            #2;
            acc = s_if.arready;
            tick();
        end
        if (acc) s_if.arvalid = 1'b0;
    endtask

    task automatic send_aw(input int budget, output bit acc);
        s_if.awvalid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < budget && !acc; c++) begin
            #2;
            acc = s_if.awready;
            tick();
        end
        if (acc) s_if.awvalid = 1'b0;
    endtask

    task automatic ret_r(input int n);
        m_if.rvalid = 1'b1;
        m_if.rlast  = 1'b1;
        s_if.rready = 1'b1;
        repeat (n) tick();
        m_if.rvalid = 1'b0;
        m_if.rlast  = 1'b0;
    endtask

    task automatic ret_b(input int n);
        m_if.bvalid = 1'b1;
        s_if.bready = 1'b1;
        repeat (n) tick();
        m_if.bvalid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && m_if.arvalid && m_if.arready) begin
            if (exp_ar.size() == 0) begin
                check("ar_sb_empty", 64'(exp_ar.size()), 64'd1);
            end else begin
                exp_addr = exp_ar.pop_front();
                check("ar_addr", 64'(m_if.araddr), 64'(exp_addr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout tests=%0d", tests);
        $fatal(1, "bench timeout");
    end

    initial begin
        s_if.arvalid = 0; s_if.araddr = 0; s_if.arlen = 0; s_if.awvalid = 0; s_if.awaddr = 0;
        s_if.awlen = 0; s_if.wvalid = 0; s_if.wdata = 0; s_if.wlast = 0; s_if.bready = 0; s_if.rready = 0;
        m_if.arready = 1; m_if.awready = 1; m_if.wready = 0; m_if.bvalid = 0;
        m_if.rvalid = 0; m_if.rlast = 0; m_if.rdata = 0;

        // Reset: AR/AW gated even with valid and ready both high
        s_if.arvalid = 1; s_if.awvalid = 1;
        #12;
        check("rst_m_arvalid", m_if.arvalid, 0);
        check("rst_s_arready", s_if.arready, 0);
        check("rst_m_awvalid", m_if.awvalid, 0);
        check("rst_s_awready", s_if.awready, 0);
        check("rst_rd_cnt", rd_out, 0);
        check("rst_wr_cnt", wr_out, 0);
        check("rst_drain_ack", drain_ack, 0);
        check("rst_timeout", timeout_err, 0);
        s_if.arvalid = 0; s_if.awvalid = 0;
        tick();
        rst_n = 1;
        tick();

        // Calibration hold-off, then AR forwarded two cycles after phy_init_done
        send_ar(32'hA0, 0, 100, ok);
        check("init_block", ok, 0);
        phy_init_done = 1;
        #2 check("init_p0", m_if.arvalid, 0);
        tick();
        #2 check("init_p1", m_if.arvalid, 0);
        tick();
        #2 check("init_p2", m_if.arvalid, 1);
        tick();
        s_if.arvalid = 0;
        check("init_rd1", rd_out, 1);
        ret_r(1);
        check("init_rd0", rd_out, 0);

        // Read limit of 4: 5th and 6th each wait for one R-last
        for (int i = 0; i < 4; i++) begin
            send_ar(32'h100 + i, 0, 5, ok);
            check("lim_acc", ok, 1);
        end
        check("lim_rd4", rd_out, 4);
        for (int i = 4; i < 6; i++) begin
            send_ar(32'h100 + i, 0, 10, ok);
            check("lim_stall", ok, 0);
            check("lim_hold4", rd_out, 4);
            ret_r(1);
            #2 check("lim_reen", m_if.arvalid, 1);
            tick();
            s_if.arvalid = 0;
        end
        check("lim_rd4b", rd_out, 4);
        ret_r(4);
        check("lim_rd0", rd_out, 0);

        // Writes: simultaneous AW and B at count 3 cancel, then the limit
        for (int i = 0; i < 3; i++) begin
            send_aw(5, ok);
            check("aw_acc", ok, 1);
        end
        s_if.awvalid = 1; m_if.bvalid = 1; s_if.bready = 1;
        #2 check("aw_b_rdy", s_if.awready, 1);
        tick();
        s_if.awvalid = 0; m_if.bvalid = 0;
        check("aw_b_cancel", wr_out, 3);
        send_aw(5, ok);
        check("aw_4th", ok, 1);
        send_aw(6, ok);
        check("aw_lim_stall", ok, 0);
        ret_b(1);
        #2 check("aw_reen", s_if.awready, 1);
        tick();
        s_if.awvalid = 0;
        ret_b(4);
        check("aw_wr0", wr_out, 0);

        // Drain with an 8-beat read outstanding
        send_ar(32'h200, 7, 5, ok);
        check("dr_acc", ok, 1);
        drain_req = 1;
        tick();
        tick();
        send_ar(32'h300, 0, 5, ok);
        check("dr_block", ok, 0);
        check("dr_ack_busy", drain_ack, 0);
        m_if.rvalid = 1; s_if.rready = 1; m_if.rlast = 0;
        for (int b = 0; b < 7; b++) begin
            m_if.rdata = 64'hD000 + b;
            tick();
        end
        check("dr_rdata", s_if.rdata, 64'hD006);
        m_if.rlast = 1;
        #2 check("dr_ack_last", drain_ack, 0);
        tick();
        m_if.rvalid = 0; m_if.rlast = 0;
        #2 check("dr_ack", drain_ack, 1);
        check("dr_rd0", rd_out, 0);
        check("dr_ar_held", m_if.arvalid, 0);
        tick();
        drain_req = 0;
        #2 check("dr_x0", m_if.arvalid, 0);
        tick();
        #2 check("dr_x1", m_if.arvalid, 0);
        check("dr_ack_off", drain_ack, 0);
        tick();
        #2 check("dr_x2", m_if.arvalid, 1);
        tick();
        s_if.arvalid = 0;
        ret_r(1);

        // Calibration lost with two reads outstanding
        send_ar(32'h400, 0, 5, ok);
        send_ar(32'h401, 0, 5, ok);
        check("phy_rd2", rd_out, 2);
        phy_init_done = 0;
        tick();
        tick();
        send_ar(32'h402, 0, 5, ok);
        check("phy_block", ok, 0);
        check("phy_keep2", rd_out, 2);
        s_if.wvalid = 1; s_if.wdata = 64'hCAFE; m_if.wready = 1;
        m_if.rvalid = 1; m_if.rdata = 64'hBEEF;
        #2 check("phy_wvalid", m_if.wvalid, 1);
        check("phy_wdata", m_if.wdata, 64'hCAFE);
        check("phy_wready", s_if.wready, 1);
        check("phy_rvalid", s_if.rvalid, 1);
        check("phy_rdata", s_if.rdata, 64'hBEEF);
        tick();
        s_if.wvalid = 0; m_if.wready = 0; m_if.rvalid = 0;
        ret_r(2);
        check("phy_rd0", rd_out, 0);
        phy_init_done = 1;
        tick();
        #2 check("phy_re1", m_if.arvalid, 0);
        tick();
        #2 check("phy_re2", m_if.arvalid, 1);
        tick();
        s_if.arvalid = 0;
        ret_r(1);

        // Watchdog: one read left unanswered
`ifdef AXI4_LIMITER_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        send_ar(32'h500, 0, 5, ok);
        repeat (50) tick();
        check("to_early", timeout_err, 0);
        repeat (60) tick();
        check("to_set", timeout_err, exp_to);
        ret_r(1);
        repeat (5) tick();
        check("to_sticky", timeout_err, exp_to);
        check("sb_drained", 64'(exp_ar.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
